// File: rtl/glb_core_pcfg_switch.sv
// Parallel-config stream switch: picks local DMA or west chain, forwards east (1-cycle), buffers to CGRA columns.
// Optional column filter for local delivery: define GLB_PCFG_COL_FILTER_EN.
package glb_pcfg_pkg;
    localparam int CFG_ADDR_WIDTH = 32;
    localparam int CFG_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      cfg_rd_en;
        logic                      cfg_wr_en;
        logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
        logic [CFG_DATA_WIDTH-1:0] cfg_data;
    } cgra_cfg_t;

    typedef struct packed {
        logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
        logic [CFG_DATA_WIDTH-1:0] cfg_data;
    } cfg_payload_t;
endpackage

module glb_core_pcfg_switch
    import glb_pcfg_pkg::*;
#(
    parameter int TILE_SEL_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH          = 4,
    parameter int COL_LSB             = 8,
    parameter int COL_WIDTH           = 8,
    parameter int COLS_PER_TILE       = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
    input  logic                           cfg_pc_dma_mode,
    input  cgra_cfg_t                      cgra_cfg_c2sw,
    input  cgra_cfg_t                      cgra_cfg_wsti,
    output cgra_cfg_t                      cgra_cfg_esto,
    output cgra_cfg_t                      cgra_cfg_g2f,
    input  logic                           cgra_cfg_stall,
    output logic                           pcfg_busy,
    output logic                           pcfg_overflow,
    input  logic                           pcfg_overflow_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cgra_cfg_t          w_src;
    cgra_cfg_t          w_sel;
    logic               w_local;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_drop;
    logic               w_unused;

    cgra_cfg_t          r_esto;
    cgra_cfg_t          r_g2f;
    cfg_payload_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_src = cfg_pc_dma_mode ? cgra_cfg_c2sw : cgra_cfg_wsti;
        w_sel = '0;
        if (w_src.cfg_wr_en) begin
            w_sel.cfg_wr_en = 1'b1;
            w_sel.cfg_addr  = w_src.cfg_addr;
            w_sel.cfg_data  = w_src.cfg_data;
        end
    end

`ifdef GLB_PCFG_COL_FILTER_EN
    localparam int COL_SHIFT = $clog2(COLS_PER_TILE);
    logic [COL_WIDTH-1:0] w_col;
    assign w_col    = w_sel.cfg_addr[COL_LSB +: COL_WIDTH];
    assign w_local  = (32'(w_col >> COL_SHIFT) == 32'(glb_tile_id));
    assign w_unused = w_src.cfg_rd_en;
`else
    assign w_local  = 1'b1;
    assign w_unused = ^{w_src.cfg_rd_en, glb_tile_id};
`endif

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & ~cgra_cfg_stall;
    assign w_push  = w_sel.cfg_wr_en & w_local;
    // A simultaneous pop frees the slot a push into a full buffer needs.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_esto     <= '0;
            r_g2f      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_esto <= w_sel;

            r_g2f <= '0;
            if (w_pop) begin
                r_g2f.cfg_wr_en <= 1'b1;
                r_g2f.cfg_addr  <= r_mem[r_rd_ptr].cfg_addr;
                r_g2f.cfg_data  <= r_mem[r_rd_ptr].cfg_data;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (pcfg_overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: buffer storage has no reset; validity is tracked by the reset count and pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= '{cfg_addr: w_sel.cfg_addr, cfg_data: w_sel.cfg_data};
        end
    end

    assign cgra_cfg_esto = r_esto;
    assign cgra_cfg_g2f  = r_g2f;
    assign pcfg_busy     = (r_count != '0) | r_esto.cfg_wr_en;
    assign pcfg_overflow = r_overflow;

endmodule

// File: tb/tb_glb_core_pcfg_switch.sv
// Self-checking bench for glb_core_pcfg_switch: directed scenarios plus random traffic vs a queue model.
module tb_glb_core_pcfg_switch;
    import glb_pcfg_pkg::*;

    localparam int TSW   = 5;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset;
    logic [TSW-1:0]  glb_tile_id;
    logic            cfg_pc_dma_mode;
    cgra_cfg_t       cgra_cfg_c2sw;
    cgra_cfg_t       cgra_cfg_wsti;
    cgra_cfg_t       cgra_cfg_esto;
    cgra_cfg_t       cgra_cfg_g2f;
    logic            cgra_cfg_stall;
    logic            pcfg_busy;
    logic            pcfg_overflow;
    logic            pcfg_overflow_clr;

    glb_core_pcfg_switch #(
        .TILE_SEL_ADDR_WIDTH(TSW),
        .FIFO_DEPTH         (DEPTH),
        .COL_LSB            (8),
        .COL_WIDTH          (8),
        .COLS_PER_TILE      (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .glb_tile_id      (glb_tile_id),
        .cfg_pc_dma_mode  (cfg_pc_dma_mode),
        .cgra_cfg_c2sw    (cgra_cfg_c2sw),
        .cgra_cfg_wsti    (cgra_cfg_wsti),
        .cgra_cfg_esto    (cgra_cfg_esto),
        .cgra_cfg_g2f     (cgra_cfg_g2f),
        .cgra_cfg_stall   (cgra_cfg_stall),
        .pcfg_busy        (pcfg_busy),
        .pcfg_overflow    (pcfg_overflow),
        .pcfg_overflow_clr(pcfg_overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of buffered writes and expected registered outputs.
    cgra_cfg_t q[$];
    cgra_cfg_t m_esto;
    cgra_cfg_t m_g2f;
    bit        m_ovf;
    int        n_checks;
    int        n_pass;
    int        g2f_seen;

    function automatic bit is_local(logic [31:0] addr);
`ifdef GLB_PCFG_COL_FILTER_EN
        int col;
        col = (addr >> 8) & 32'hFF;
        return (col / 2) == int'(glb_tile_id);
`else
        return (addr != 32'h1) || 1'b1;
`endif
    endfunction

    function automatic bit exp_busy();
        return (q.size() != 0) || m_esto.cfg_wr_en;
    endfunction

    function automatic cgra_cfg_t rnd_cfg(bit wr);
        cgra_cfg_t c;
        c.cfg_rd_en = 1'($urandom_range(0, 1));
        c.cfg_wr_en = wr;
        c.cfg_addr  = $urandom;
        c.cfg_data  = $urandom;
        return c;
    endfunction

    function automatic logic [31:0] addr_for_col(int col);
        logic [31:0] r;
        r = $urandom;
        r[15:8] = 8'(col);
        return r;
    endfunction

    function automatic cgra_cfg_t local_wr();
        cgra_cfg_t c;
        c = rnd_cfg(1'b1);
        c.cfg_addr = addr_for_col(int'(glb_tile_id) * 2 + int'($urandom_range(0, 1)));
        return c;
    endfunction

    task automatic idle_inputs();
        cgra_cfg_c2sw     = rnd_cfg(1'b0);
        cgra_cfg_wsti     = rnd_cfg(1'b0);
        pcfg_overflow_clr = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_esto = '0;
        m_g2f  = '0;
        m_ovf  = 1'b0;
    endtask

    // Advances the model by one clock from the current inputs, then the DUT; returns at edge+1.
    task automatic tick();
        cgra_cfg_t s;
        cgra_cfg_t w;
        bit        drop;
        s = cfg_pc_dma_mode ? cgra_cfg_c2sw : cgra_cfg_wsti;
        w = '0;
        if (s.cfg_wr_en) begin
            w.cfg_wr_en = 1'b1;
            w.cfg_addr  = s.cfg_addr;
            w.cfg_data  = s.cfg_data;
        end
        m_esto = w;
        m_g2f  = '0;
        if (q.size() != 0 && !cgra_cfg_stall) m_g2f = q.pop_front();
        drop = 1'b0;
        if (w.cfg_wr_en && is_local(w.cfg_addr)) begin
            if (q.size() < DEPTH) q.push_back(w);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (pcfg_overflow_clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        glb_tile_id = TSW'(1);
        cfg_pc_dma_mode = 1'b1;
        cgra_cfg_stall = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
            $display("FAIL reset: got esto=%h g2f=%h busy=%b ovf=%b, expected all zero",
                     cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_dma_b2b();
        cfg_pc_dma_mode = 1'b1;
        cgra_cfg_stall  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i < 3) cgra_cfg_c2sw = local_wr();
            cgra_cfg_wsti = rnd_cfg(1'b1);
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL dma_b2b cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_west();
        cfg_pc_dma_mode = 1'b0;
        cgra_cfg_stall  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            cgra_cfg_c2sw = rnd_cfg(1'b1);
            if (i == 0) begin
                cgra_cfg_wsti.cfg_wr_en = 1'b1;
                cgra_cfg_wsti.cfg_addr  = 32'h0000_0105;
                cgra_cfg_wsti.cfg_data  = 32'hA5A5_5A5A;
            end
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL west cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        cfg_pc_dma_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            cgra_cfg_stall = (i < 5);
            if (i < 5) cgra_cfg_c2sw = local_wr();
            pcfg_overflow_clr = (i == 10);
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL overflow cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
            if (cgra_cfg_g2f.cfg_wr_en) g2f_seen++;
            if (i == 4) begin
                n_checks++;
                if (pcfg_overflow !== 1'b1 || pcfg_busy !== 1'b1)
                    $display("FAIL overflow_set: got ovf=%b busy=%b, expected ovf=1 busy=1", pcfg_overflow, pcfg_busy);
                else n_pass++;
            end
        end
        n_checks++;
        if (pcfg_overflow !== 1'b0 || pcfg_busy !== 1'b0 || g2f_seen != DEPTH)
            $display("FAIL overflow_drain: got ovf=%b busy=%b g2f_writes=%0d, expected ovf=0 busy=0 g2f_writes=%0d",
                     pcfg_overflow, pcfg_busy, g2f_seen, DEPTH);
        else n_pass++;
    endtask

    task automatic test_full_stream();
        cfg_pc_dma_mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            cgra_cfg_stall = (i < 4);
            if (i < 10) cgra_cfg_c2sw = local_wr();
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL full_stream cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_filter();
        cfg_pc_dma_mode = 1'b1;
        cgra_cfg_stall  = 1'b0;
        glb_tile_id     = TSW'(1);
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i == 0 || i == 1) begin
                cgra_cfg_c2sw = rnd_cfg(1'b1);
                cgra_cfg_c2sw.cfg_addr = addr_for_col(i == 0 ? 2 : 5);
            end
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL filter cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cfg_pc_dma_mode   = 1'($urandom_range(0, 1));
            cgra_cfg_stall    = ($urandom_range(0, 9) < 5);
            pcfg_overflow_clr = ($urandom_range(0, 15) == 0);
            cgra_cfg_c2sw     = rnd_cfg($urandom_range(0, 3) != 0);
            cgra_cfg_wsti     = rnd_cfg($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) cgra_cfg_c2sw.cfg_addr = addr_for_col(int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) == 1) cgra_cfg_wsti.cfg_addr = addr_for_col(int'($urandom_range(0, 5)));
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL random cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
        // Drain and clear so the next scenario starts from a known idle state.
        cgra_cfg_stall = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle_inputs();
            pcfg_overflow_clr = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        cfg_pc_dma_mode = 1'b1;
        cgra_cfg_stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            cgra_cfg_c2sw = local_wr();
            tick();
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
            $display("FAIL reset_mid: got esto=%h g2f=%h busy=%b ovf=%b, expected all zero",
                     cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cgra_cfg_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i == 0) cgra_cfg_c2sw = local_wr();
            tick();
            n_checks++;
            if ({cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow} !== {m_esto, m_g2f, exp_busy(), m_ovf})
                $display("FAIL reset_mid_after cyc%0d: got esto=%h g2f=%h busy=%b ovf=%b, expected esto=%h g2f=%h busy=%b ovf=%b",
                         i, cgra_cfg_esto, cgra_cfg_g2f, pcfg_busy, pcfg_overflow, m_esto, m_g2f, exp_busy(), m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        g2f_seen = 0;
        test_reset();
        test_dma_b2b();
        test_west();
        test_overflow();
        test_full_stream();
        test_filter();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
